// File: rtl/snitch_cluster_periph_regs.sv
// snitch_cluster_periph_regs: cluster peripheral register block with TCDM bounds, fetch-enable,
// wake-up, hardware barrier and cycle/TCDM performance counters behind a one-deep response register.
module snitch_cluster_periph_regs #(
    parameter int unsigned        NrCores     = 4,
    parameter int unsigned        MetaIdWidth = 1,
    parameter logic [31:0]        TCDMStart   = 32'h0000_0000,
    parameter logic [31:0]        TCDMEnd     = 32'h1000_0000,
    parameter logic [NrCores-1:0] FetchEnRst  = '0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [31:0]            req_addr_i,
    input  logic [MetaIdWidth-1:0] req_id_i,
    input  logic [3:0]             req_amo_i,
    input  logic                   req_write_i,
    input  logic [31:0]            req_data_i,
    input  logic [3:0]             req_strb_i,
    output logic                   resp_valid_o,
    input  logic                   resp_ready_i,
    output logic [31:0]            resp_data_o,
    output logic [MetaIdWidth-1:0] resp_id_o,
    output logic                   resp_write_o,
    output logic                   resp_error_o,
    input  logic                   tcdm_accessed_i,
    input  logic                   tcdm_congested_i,
    output logic [NrCores-1:0]     fetch_enable_o,
    output logic [NrCores-1:0]     wake_up_o
);
    logic               accept, known, ok, wr_ok, bar_hit, bar_done, wake_wr;
    logic [15:0]        off;
    logic [31:0]        rdata, wmask, scratch_q, acc_q, cong_q;
    logic [63:0]        cycle_q;
    logic [4:0]         barrier_q;
    logic [NrCores-1:0] fetch_en_q, wake_d, wake_q;

    assign req_ready_o = !resp_valid_o || resp_ready_i;
    assign accept      = req_valid_i && req_ready_o;
    assign off         = req_addr_i[15:0];
    assign known       = off inside {16'h0000, 16'h0008, 16'h0010, 16'h0018, 16'h0020, 16'h0028,
                                     16'h0030, 16'h0034, 16'h0038, 16'hFFF0, 16'hFFF8};
    assign ok          = req_addr_i[31:16] == 16'h4000 && req_addr_i[1:0] == 2'b00 && req_amo_i == 4'h0 && known;
    assign wr_ok       = accept && ok && req_write_i;
    assign wake_wr     = wr_ok && off == 16'h0028;
    assign bar_hit     = accept && ok && !req_write_i && off == 16'h0038;
    assign bar_done    = bar_hit && 6'(barrier_q) + 6'd1 == 6'(NrCores);
    assign wmask       = {{8{req_strb_i[3]}}, {8{req_strb_i[2]}}, {8{req_strb_i[1]}}, {8{req_strb_i[0]}}};

    always_comb begin
        rdata = '0;
        case (off)
            16'h0000: rdata = TCDMStart;
            16'h0008: rdata = TCDMEnd;
            16'h0010: rdata = 32'(NrCores);
            16'h0018: rdata = 32'(fetch_en_q);
            16'h0020: rdata = scratch_q;
            16'h0030: rdata = cycle_q[31:0];
            16'h0034: rdata = cycle_q[63:32];
            16'h0038: rdata = 32'(barrier_q);
            16'hFFF0: rdata = acc_q;
            16'hFFF8: rdata = cong_q;
            default:  rdata = '0;
        endcase
    end

    // Barrier completion and a WakeUp write are mutually exclusive: one request per cycle.
    always_comb begin
        wake_d = '0;
        if (bar_done || (wake_wr && req_data_i == 32'hFFFF_FFFF)) wake_d = '1;
        else if (wake_wr && req_data_i < 32'(NrCores)) wake_d = NrCores'(1) << req_data_i[4:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_valid_o <= 1'b0;
            resp_data_o  <= '0;
            resp_id_o    <= '0;
            resp_write_o <= 1'b0;
            resp_error_o <= 1'b0;
            fetch_en_q   <= FetchEnRst;
            scratch_q    <= '0;
            barrier_q    <= '0;
            cycle_q      <= '0;
            acc_q        <= '0;
            cong_q       <= '0;
            wake_q       <= '0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
            wake_q  <= wake_d;
            acc_q   <= (wr_ok && off == 16'hFFF0) ? '0 : acc_q + 32'(tcdm_accessed_i);
            cong_q  <= (wr_ok && off == 16'hFFF8) ? '0 : cong_q + 32'(tcdm_congested_i);
            if (wr_ok && off == 16'h0018)
                fetch_en_q <= (fetch_en_q & ~wmask[NrCores-1:0]) | (req_data_i[NrCores-1:0] & wmask[NrCores-1:0]);
            if (wr_ok && off == 16'h0020) scratch_q <= (scratch_q & ~wmask) | (req_data_i & wmask);
            if (bar_hit) barrier_q <= bar_done ? '0 : barrier_q + 5'd1;
            if (accept) begin
                resp_valid_o <= 1'b1;
                resp_data_o  <= (ok && !req_write_i) ? rdata : '0;
                resp_id_o    <= req_id_i;
                resp_write_o <= req_write_i;
                resp_error_o <= !ok;
            end else if (resp_ready_i) begin
                resp_valid_o <= 1'b0;
            end
        end
    end

    assign fetch_enable_o = fetch_en_q;
    assign wake_up_o      = wake_q;
endmodule

// File: tb/tb_snitch_cluster_periph_regs.sv
// tb_snitch_cluster_periph_regs: directed plus randomized requests checked against a
// register-level reference model of the peripheral block.
module tb_snitch_cluster_periph_regs;
    localparam int NC = 4;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [31:0] req_addr = '0, req_data = '0;
    logic [0:0]  req_id = '0, resp_id;
    logic [3:0]  req_amo = '0, req_strb = '0;
    logic        resp_valid, resp_ready = 1'b1, resp_write, resp_error;
    logic [31:0] resp_data;
    logic        acc_s = 1'b0, cong_s = 1'b0;
    logic [NC-1:0] fetch_en, wake;

    int n_cmp = 0, n_bad = 0;

    logic [31:0] m_scr, m_acc, m_cong;
    logic [NC-1:0] m_fe;
    logic [63:0] m_cyc;
    int          m_bar;
    logic [31:0] last_data;
    logic [NC-1:0] last_wake;
    logic        last_err;

    snitch_cluster_periph_regs #(.NrCores(NC), .MetaIdWidth(1)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .req_id_i(req_id), .req_amo_i(req_amo), .req_write_i(req_write),
        .req_data_i(req_data), .req_strb_i(req_strb),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_data_o(resp_data),
        .resp_id_o(resp_id), .resp_write_o(resp_write), .resp_error_o(resp_error),
        .tcdm_accessed_i(acc_s), .tcdm_congested_i(cong_s),
        .fetch_enable_o(fetch_en), .wake_up_o(wake)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        m_scr = '0; m_fe = '0; m_bar = 0; m_acc = '0; m_cong = '0; m_cyc = '0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // One clock cycle: optional request plus counter strobes, then check everything after the edge.
    task automatic step(input logic v, input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] s, input logic [3:0] amo, input logic id,
                        input logic ac, input logic cg);
        logic [15:0] off;
        logic        ok, clr_a, clr_c;
        logic [31:0] exp_rd;
        logic [NC-1:0] exp_wk;
        @(negedge clk);
        req_valid = v; req_addr = a; req_write = w; req_data = d; req_strb = s;
        req_amo = amo; req_id = id; acc_s = ac; cong_s = cg;
        off = a[15:0];
        ok = a[31:16] == 16'h4000 && a[1:0] == 2'b00 && amo == 4'h0 &&
             (off inside {16'h00, 16'h08, 16'h10, 16'h18, 16'h20, 16'h28, 16'h30, 16'h34, 16'h38, 16'hFFF0, 16'hFFF8});
        exp_rd = '0; exp_wk = '0; clr_a = 1'b0; clr_c = 1'b0;
        if (v && ok && !w) begin
            if (off == 16'h00) exp_rd = 32'h0;
            else if (off == 16'h08) exp_rd = 32'h1000_0000;
            else if (off == 16'h10) exp_rd = NC;
            else if (off == 16'h18) exp_rd = 32'(m_fe);
            else if (off == 16'h20) exp_rd = m_scr;
            else if (off == 16'h30) exp_rd = m_cyc[31:0];
            else if (off == 16'h34) exp_rd = m_cyc[63:32];
            else if (off == 16'hFFF0) exp_rd = m_acc;
            else if (off == 16'hFFF8) exp_rd = m_cong;
            else if (off == 16'h38) begin
                exp_rd = 32'(m_bar);
                if (m_bar + 1 == NC) begin m_bar = 0; exp_wk = '1; end
                else m_bar++;
            end
        end
        if (v && ok && w) begin
            if (off == 16'h18) m_fe = NC'(merge(32'(m_fe), d, s));
            if (off == 16'h20) m_scr = merge(m_scr, d, s);
            if (off == 16'hFFF0) clr_a = 1'b1;
            if (off == 16'hFFF8) clr_c = 1'b1;
            if (off == 16'h28 && d == 32'hFFFF_FFFF) exp_wk = '1;
            else if (off == 16'h28 && d < NC) exp_wk[d] = 1'b1;
        end
        m_acc = clr_a ? 32'h0 : m_acc + 32'(ac);
        m_cong = clr_c ? 32'h0 : m_cong + 32'(cg);
        m_cyc++;
        @(posedge clk);
        #1;
        chk("resp_valid", 64'(resp_valid), 64'(v));
        if (v) begin
            chk("resp_data", 64'(resp_data), 64'(exp_rd));
            chk("resp_id", 64'(resp_id), 64'(id));
            chk("resp_write", 64'(resp_write), 64'(w));
            chk("resp_error", 64'(resp_error), 64'(!ok));
        end
        chk("wake_up", 64'(wake), 64'(exp_wk));
        chk("fetch_enable", 64'(fetch_en), 64'(m_fe));
        chk("req_ready", 64'(req_ready), 64'd1);
        last_data = resp_data; last_wake = wake; last_err = resp_error;
    endtask

    task automatic rd(input logic [31:0] a, input logic id);
        step(1'b1, a, 1'b0, 32'h0, 4'h0, 4'h0, id, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        step(1'b1, a, 1'b1, d, s, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic ac, input logic cg);
        step(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 4'h0, 1'b0, ac, cg);
    endtask

    logic [15:0] offs [11] = '{16'h00, 16'h08, 16'h10, 16'h18, 16'h20, 16'h28, 16'h30, 16'h34, 16'h38, 16'hFFF0, 16'hFFF8};

    initial begin
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_data", 64'(resp_data), 64'd0);
        chk("rst_resp_id", 64'(resp_id), 64'd0);
        chk("rst_resp_write", 64'(resp_write), 64'd0);
        chk("rst_resp_error", 64'(resp_error), 64'd0);
        chk("rst_fetch", 64'(fetch_en), 64'd0);
        chk("rst_wake", 64'(wake), 64'd0);
        rst_ni = 1'b1;

        rd(32'h4000_0010, 1'b1);
        chk("nrcores", 64'(last_data), 64'd4);
        rd(32'h4000_0000, 1'b0);
        rd(32'h4000_0008, 1'b0);
        chk("tcdm_end", 64'(last_data), 64'h1000_0000);

        wr(32'h4000_0020, 32'hDEAD_BEEF, 4'b0101);
        rd(32'h4000_0020, 1'b1);
        chk("scratch_strb", 64'(last_data), 64'h00AD_00EF);
        @(negedge clk);
        req_valid = 1'b0; acc_s = 1'b0; cong_s = 1'b0; resp_ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            m_cyc++;
            chk("stall_valid", 64'(resp_valid), 64'd1);
            chk("stall_data", 64'(resp_data), 64'h00AD_00EF);
            chk("stall_id", 64'(resp_id), 64'd1);
            chk("stall_ready", 64'(req_ready), 64'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        m_cyc++;
        chk("stall_release", 64'(resp_valid), 64'd0);

        for (int i = 0; i < 4; i++) begin
            rd(32'h4000_0038, 1'b0);
            chk("barrier_count", 64'(last_data), 64'(i));
            chk("barrier_wake", 64'(last_wake), (i == 3) ? 64'hF : 64'h0);
        end
        idle(1'b0, 1'b0);
        rd(32'h4000_0038, 1'b0);
        chk("barrier_restart", 64'(last_data), 64'd0);

        wr(32'h4000_0028, 32'd2, 4'hF);
        chk("wake_bit2", 64'(last_wake), 64'b0100);
        idle(1'b0, 1'b0);
        wr(32'h4000_0028, 32'd7, 4'hF);
        chk("wake_ignored_err", 64'(last_err), 64'd0);
        wr(32'h4000_0028, 32'hFFFF_FFFF, 4'hF);
        chk("wake_all", 64'(last_wake), 64'hF);

        wr(32'h4000_FFF0, 32'h0, 4'h0);
        repeat (10) idle(1'b1, 1'b0);
        rd(32'h4000_FFF0, 1'b0);
        chk("acc_10", 64'(last_data), 64'd10);
        wr(32'h4000_FFF0, 32'h1234, 4'h0);
        rd(32'h4000_FFF0, 1'b0);
        chk("acc_cleared", 64'(last_data), 64'd0);
        step(1'b1, 32'h4000_FFF8, 1'b1, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        rd(32'h4000_FFF8, 1'b0);
        chk("cong_clear_wins", 64'(last_data), 64'd0);

        rd(32'h4000_0040, 1'b0);
        chk("bad_off_err", 64'(last_err), 64'd1);
        step(1'b1, 32'h4000_0020, 1'b1, 32'h1111_1111, 4'hF, 4'h2, 1'b0, 1'b0, 1'b0);
        chk("amo_err", 64'(last_err), 64'd1);
        rd(32'h4000_0020, 1'b0);
        chk("amo_no_write", 64'(last_data), 64'h00AD_00EF);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a, d;
            int sel;
            sel = $urandom_range(0, 14);
            a = {16'h4000, offs[$urandom_range(0, 10)]};
            if (sel == 11) a = {16'h4000, 16'($urandom)};
            if (sel == 12) a = $urandom;
            if (sel == 13) a[1:0] = 2'($urandom_range(1, 3));
            d = $urandom;
            if (a[15:0] == 16'h28 && $urandom_range(0, 1) == 1) d = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFF : $urandom_range(0, 7);
            step(sel != 14, a, 1'($urandom), d, 4'($urandom),
                 ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'h0,
                 1'($urandom), 1'($urandom), 1'($urandom));
        end

        wr(32'h4000_0018, 32'h0000_000A, 4'h1);
        chk("fetch_set", 64'(fetch_en), 64'hA);
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h4000_0028; req_write = 1'b1; req_data = 32'hFFFF_FFFF;
        req_strb = 4'hF; req_amo = 4'h0; acc_s = 1'b0; cong_s = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("pre_rst_valid", 64'(resp_valid), 64'd1);
        chk("pre_rst_wake", 64'(wake), 64'hF);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(resp_valid), 64'd0);
        chk("mid_rst_wake", 64'(wake), 64'd0);
        chk("mid_rst_fetch", 64'(fetch_en), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        reset_model();
        rd(32'h4000_0018, 1'b0);
        rd(32'h4000_0020, 1'b1);
        chk("scratch_after_rst", 64'(last_data), 64'd0);
        idle(1'b0, 1'b0);
        rd(32'h4000_0030, 1'b0);
        rd(32'h4000_0038, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
